// File: rtl/shift_sequence_controller.sv
// shift_sequence_controller
// Sequencer for the serial-in shift register / pattern detector on the lab
// board. The debounced step button advances the window by one bit, taking
// the current slide-switch value as the new bit. A match is only accepted
// once the window holds WIDTH valid bits. The match indication is stretched
// for HOLD_CYCLES clocks so it is visible on an LED, and a saturating tally
// of accepted matches is kept for the display.
//
// Ports
//   system_clk  single clock for all logic
//   reset       asynchronous, active-low; clears all state
//   step        debounced step level, asynchronous to system_clk
//   din         serial data bit, asynchronous to system_clk
//   clear       synchronous soft clear, active-high (synchronizers keep running)
//   overlap     1 = overlapping detection, 0 = non-overlapping
//   q           shift register contents, q[0] = newest bit
//   dout        stretched match indicator
//   fill        window holds WIDTH valid bits since last clear/match
//   match_cnt   saturating count of accepted matches
//   state       FSM state: 0 FILL, 1 ARMED, 2 HOLD
//
// state | meaning
// FILL  | fewer than WIDTH valid bits in the window, no match possible
// ARMED | window full, waiting for a matching shift
// HOLD  | dout stretched high, timer counting down to release

module shift_sequence_controller #(
  parameter int              WIDTH       = 6,
  parameter logic [WIDTH-1:0] PATTERN    = 6'b101011,
  parameter int              HOLD_CYCLES = 25_000_000,
  parameter int              CNT_W       = 8
) (
  input  logic             system_clk,
  input  logic             reset,
  input  logic             step,
  input  logic             din,
  input  logic             clear,
  input  logic             overlap,
  output logic [WIDTH-1:0] q,
  output logic             dout,
  output logic             fill,
  output logic [CNT_W-1:0] match_cnt,
  output logic [1:0]       state
);

  localparam int BC_W  = $clog2(WIDTH + 1);
  localparam int TMR_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [BC_W-1:0]  CNT_FULL = BC_W'(WIDTH);
  localparam logic [TMR_W-1:0] HOLD_M1  = TMR_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_ARMED = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // Synchronizers: the third step flop exists only for rise detection.
  logic step_s1_q, step_s2_q, step_s3_q;
  logic din_s1_q, din_s2_q;

  logic [WIDTH-1:0] q_q;
  logic [BC_W-1:0]  bit_cnt_q;
  logic [TMR_W-1:0] timer_q;
  logic             dout_q;
  logic [CNT_W-1:0] mcnt_q;
  state_e           state_q;

  logic             step_pulse;
  logic [WIDTH-1:0] shift_d;
  logic [BC_W-1:0]  cnt_sat;
  logic [BC_W-1:0]  bit_cnt_d;
  logic             match_acc;

  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      step_s1_q <= 1'b0;
      step_s2_q <= 1'b0;
      step_s3_q <= 1'b0;
      din_s1_q  <= 1'b0;
      din_s2_q  <= 1'b0;
    end else begin
      step_s1_q <= step;
      step_s2_q <= step_s1_q;
      step_s3_q <= step_s2_q;
      din_s1_q  <= din;
      din_s2_q  <= din_s1_q;
    end
  end

  assign step_pulse = step_s2_q & ~step_s3_q;

  // Match is judged on the post-shift window and post-shift bit count, so
  // the bit arriving on this step already counts toward a full window.
  always_comb begin
    shift_d   = {q_q[WIDTH-2:0], din_s2_q};
    cnt_sat   = (bit_cnt_q == CNT_FULL) ? CNT_FULL : bit_cnt_q + 1'b1;
    match_acc = step_pulse && (shift_d == PATTERN) && (cnt_sat == CNT_FULL);
    bit_cnt_d = bit_cnt_q;
    if (step_pulse) begin
      // Non-overlapping mode discards the window's history after a match.
      bit_cnt_d = (match_acc && !overlap) ? '0 : cnt_sat;
    end
  end

  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      q_q       <= '0;
      bit_cnt_q <= '0;
      timer_q   <= '0;
      dout_q    <= 1'b0;
      mcnt_q    <= '0;
      state_q   <= ST_FILL;
    end else if (clear) begin
      // A step landing on the clear edge is dropped on purpose.
      q_q       <= '0;
      bit_cnt_q <= '0;
      timer_q   <= '0;
      dout_q    <= 1'b0;
      mcnt_q    <= '0;
      state_q   <= ST_FILL;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      if (step_pulse) begin
        q_q <= shift_d;
      end
      if (match_acc) begin
        dout_q  <= 1'b1;
        timer_q <= HOLD_M1;
        if (mcnt_q != {CNT_W{1'b1}}) begin
          mcnt_q <= mcnt_q + 1'b1;
        end
        state_q <= ST_HOLD;
      end else begin
        case (state_q)
          ST_FILL: begin
            if (bit_cnt_d == CNT_FULL) begin
              state_q <= ST_ARMED;
            end
          end
          ST_ARMED: begin
            state_q <= ST_ARMED;
          end
          ST_HOLD: begin
            if (timer_q == '0) begin
              dout_q  <= 1'b0;
              // Release by the window status after this edge's shift.
              state_q <= (bit_cnt_d == CNT_FULL) ? ST_ARMED : ST_FILL;
            end else begin
              timer_q <= timer_q - 1'b1;
            end
          end
          default: begin
            state_q <= ST_FILL;
          end
        endcase
      end
    end
  end

  assign q         = q_q;
  assign dout      = dout_q;
  assign fill      = (bit_cnt_q == CNT_FULL);
  assign match_cnt = mcnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_shift_sequence_controller.sv
// Bench for shift_sequence_controller: directed scenarios plus randomized
// step/din/clear/overlap traffic, every cycle checked against a behavioural
// model built on a bit-history queue and match timestamps.

module tb_shift_sequence_controller;

  localparam int W    = 6;
  localparam int H    = 24;
  localparam int CW   = 3;
  localparam int MAXC = (1 << CW) - 1;
  localparam logic [W-1:0] PAT = 6'b101011;

  logic          clk;
  logic          reset;
  logic          step;
  logic          din;
  logic          clear;
  logic          overlap;
  logic [W-1:0]  q;
  logic          dout;
  logic          fill;
  logic [CW-1:0] match_cnt;
  logic [1:0]    state;

  int checks = 0;
  int errors = 0;
  int hi_cnt = 0;

  shift_sequence_controller #(
    .WIDTH(W), .PATTERN(PAT), .HOLD_CYCLES(H), .CNT_W(CW)
  ) dut (
    .system_clk(clk), .reset(reset), .step(step), .din(din),
    .clear(clear), .overlap(overlap), .q(q), .dout(dout), .fill(fill),
    .match_cnt(match_cnt), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: bits accepted since the last clear, fresh-bit count, match
  // timestamps. Step/din sample histories express the two-edge latency.
  bit m_hist[$];
  int m_fresh, m_tally, m_last, n_edge;
  bit sd1, sd2, sd3, dd1, dd2;

  function automatic logic [W-1:0] m_q();
    logic [W-1:0] v;
    v = '0;
    foreach (m_hist[i]) v = {v[W-2:0], m_hist[i]};
    return v;
  endfunction

  task automatic model_reset();
    m_hist.delete();
    m_fresh = 0;
    m_tally = 0;
    m_last  = -1000000;
    sd1 = 0; sd2 = 0; sd3 = 0; dd1 = 0; dd2 = 0;
  endtask

  task automatic model_edge();
    bit pulse, b;
    pulse = sd2 & ~sd3;
    b     = dd2;
    sd3 = sd2; sd2 = sd1; sd1 = step;
    dd2 = dd1; dd1 = din;
    n_edge++;
    if (clear) begin
      m_hist.delete();
      m_fresh = 0;
      m_tally = 0;
      m_last  = -1000000;
    end else if (pulse) begin
      m_hist.push_back(b);
      if (m_hist.size() > W) void'(m_hist.pop_front());
      m_fresh = (m_fresh < W) ? m_fresh + 1 : W;
      if (m_q() == PAT && m_fresh == W) begin
        m_tally++;
        m_last = n_edge;
        if (!overlap) m_fresh = 0;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    bit e_dout, e_fill;
    int e_cnt;
    e_dout = (n_edge - m_last) < H;
    e_fill = (m_fresh == W);
    e_cnt  = (m_tally > MAXC) ? MAXC : m_tally;
    check("q", q, m_q());
    check("dout", dout, e_dout);
    check("fill", fill, e_fill);
    check("match_cnt", match_cnt, e_cnt);
    check("state", state, e_dout ? 2 : (e_fill ? 1 : 0));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_reset();
    else model_edge();
    @(negedge clk);
    compare_all();
    if (dout === 1'b1) hi_cnt++;
  endtask

  task automatic send_bit(input bit b, input int hi, input int lo);
    din  = b;
    step = 1'b1;
    repeat (hi) tick();
    step = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic send_pattern();
    for (int i = W - 1; i >= 0; i--) send_bit(PAT[i], 2, 2);
  endtask

  initial begin
    bit stream[11];
    int sat_tab[9];
    int pidx;
    stream  = '{1, 0, 1, 0, 1, 1, 0, 1, 0, 1, 1};
    sat_tab = '{1, 2, 3, 4, 5, 6, 7, 7, 7};
    reset = 1'b0; step = 1'b0; din = 1'b0; clear = 1'b0; overlap = 1'b1;
    n_edge = 0;
    model_reset();
    tick();
    tick();
    check("rst_q", q, 0);
    check("rst_state", state, 0);
    check("rst_cnt", match_cnt, 0);
    reset = 1'b1;
    tick();

    // Single isolated match, overlapping mode.
    hi_cnt = 0;
    send_pattern();
    check("t1_q", q, 6'b101011);
    check("t1_cnt", match_cnt, 1);
    check("t1_dout", dout, 1);
    check("t1_state", state, 2);
    check("t1_fill", fill, 1);
    repeat (H + 2) tick();
    check("t1_hold_len", hi_cnt, H);
    check("t1_state_after", state, 1);
    check("t1_fill_after", fill, 1);

    // Step held high: exactly one shift.
    do_clear();
    din = 1'b1;
    step = 1'b1;
    repeat (20) tick();
    step = 1'b0;
    repeat (3) tick();
    check("t2_q", q, 6'b000001);

    // Overlapping stream: timer reloaded, second match counted.
    do_clear();
    overlap = 1'b1;
    foreach (stream[i]) send_bit(stream[i], 2, 2);
    check("t3_cnt", match_cnt, 2);
    check("t3_dout", dout, 1);
    repeat (H + 2) tick();

    // Non-overlapping: old window bits never count toward a new match.
    do_clear();
    overlap = 1'b0;
    for (int i = 0; i < 6; i++) send_bit(stream[i], 2, 2);
    check("t4_cnt1", match_cnt, 1);
    check("t4_fill1", fill, 0);
    for (int i = 6; i < 11; i++) send_bit(stream[i], 2, 2);
    check("t4_q_reuse", q, 6'b101011);
    check("t4_cnt_nooldwin", match_cnt, 1);
    send_pattern();
    check("t4_cnt2", match_cnt, 2);
    check("t4_fill2", fill, 0);

    // Clear coincident with a step pulse; the step is lost.
    din = 1'b1;
    step = 1'b1;
    tick();
    tick();
    step = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    tick();
    check("t5_q", q, 0);
    check("t5_cnt", match_cnt, 0);
    check("t5_dout", dout, 0);
    check("t5_state", state, 0);
    check("t5_fill", fill, 0);

    // Saturation of the tally.
    overlap = 1'b0;
    for (int i = 0; i < 9; i++) begin
      send_pattern();
      check("t6_sat", match_cnt, sat_tab[i]);
      repeat (H + 2) tick();
    end

    // Reset mid-HOLD drops dout without waiting for a clock.
    do_clear();
    send_pattern();
    repeat (3) tick();
    check("t7_dout_pre", dout, 1);
    #2;
    reset = 1'b0;
    #1;
    check("t7_dout_async", dout, 0);
    check("t7_q_async", q, 0);
    model_reset();
    tick();
    reset = 1'b1;
    tick();

    // Randomized traffic biased toward the target pattern.
    pidx = W - 1;
    for (int n = 0; n < 600; n++) begin
      bit b;
      if ($urandom_range(0, 39) == 0) do_clear();
      if ($urandom_range(0, 7) == 0) overlap = $urandom_range(0, 1);
      if ($urandom_range(0, 3) != 0) b = PAT[pidx];
      else b = $urandom_range(0, 1);
      pidx = (pidx == 0) ? W - 1 : pidx - 1;
      send_bit(b, $urandom_range(1, 3), $urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) repeat ($urandom_range(0, 30)) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
